i2c_resp_regs: RTL and testbench
================================

# i2c_resp_regs

Synthesizable I2C responder (target) that answers the on-board I2C masters on the DAQ, TRG and NVIO links. It oversamples SCL/SDA on CLK40 and decodes START, STOP and repeated START. It matches a 7-bit device address and exposes a simple byte-wide register bus with an auto-incrementing pointer. It is the hardware counterpart of the link masters and replaces the behavioural slave model in system simulation and on loopback test fixtures.

## Interface
- `SLAVE_ADDR`, default 7'h50: 7-bit device address answered.
- `PTR_BITS`, default 4: register pointer width; the register space is 2^PTR_BITS bytes.
- `FILT_LEN`, default 3: consecutive equal CLK40 samples required to accept a new SCL/SDA level.

Ports:
- `CLK40`, in, 1: system clock (40 MHz); the only clock.
- `RST_N`, in, 1: asynchronous, active-low reset.
- `SCL_IN`, in, 1: SCL line level (asynchronous).
- `SDA_IN`, in, 1: SDA line level (asynchronous).
- `SDA_OE`, out, 1: 1 = pull SDA low (open drain); 0 = release.
- `REG_ADDR`, out, PTR_BITS: current register pointer.
- `REG_WDATA`, out, 8: write data; valid while REG_WE=1.
- `REG_WE`, out, 1: one-cycle write strobe.
- `REG_RDATA`, in, 8: read data for REG_ADDR; combinational from the register owner.
- `SELECTED`, out, 1: high from address ACK until STOP, repeated START or NACK-idle.
- `BUS_BUSY`, out, 1: high between a detected START and a detected STOP.

## Operation
- Input path:
  - Two-FF synchronizer per line, then a filter.
  - The filter output changes only after FILT_LEN identical samples.
  - Edge pulses (`scl_rise`, `scl_fall`) and START/STOP detection use the filtered signals only.
- Bus conditions:
  - START: filtered SDA 1→0 while filtered SCL=1.
  - STOP: filtered SDA 0→1 while filtered SCL=1.
  - Both are recognised in every state.
  - START, including repeated START, goes to ADDR with bit counter=0 and SDA released.
  - STOP goes to IDLE and releases SDA.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
- Bit handling: SDA is sampled on `scl_rise`, MSB first. A 3-bit counter counts to 8.
- ADDR:
  - After 8 bits, bits[7:1] are compared with SLAVE_ADDR.
  - Mismatch: go to WAIT_STOP and never drive SDA.
  - Match: on the next `scl_fall`, assert SDA_OE and enter ADDR_ACK.
- ADDR_ACK:
  - On `scl_fall`, release SDA_OE.
  - R/W=0: enter PTR.
  - R/W=1: load the shifter from REG_RDATA, then enter RDATA.
- PTR:
  - After 8 bits, the pointer is loaded from byte[PTR_BITS-1:0]; upper bits are ignored.
  - ACK as above, then enter WDATA.
- WDATA:
  - After the 8th bit, REG_WDATA=byte and REG_WE pulses for one cycle with REG_ADDR equal to the old pointer.
  - The pointer increments on the following cycle.
  - ACK is always given, then return to WDATA.
- RDATA:
  - The shifter MSB drives SDA_OE = ~bit.
  - SDA_OE updates on each `scl_fall`, including the first bit, which is presented at the `scl_fall` that ends the prior ACK.
  - After 8 bits, on `scl_fall`: release SDA, increment the pointer, enter RDATA_ACK.
- RDATA_ACK:
  - Master ACK (SDA=0 at `scl_rise`): on `scl_fall`, reload the shifter from REG_RDATA at the new pointer, then RDATA.
  - Master NACK: enter WAIT_STOP.
- WAIT_STOP: SDA released; waits for STOP or START.
- Pointer: wraps from 2^PTR_BITS−1 to 0 and persists across transactions until a new PTR byte is received.
- No clock stretching; SCL is never driven.

## Timing
- Reset values:
  - SDA_OE=0, REG_WE=0, REG_WDATA=0, REG_ADDR=0, SELECTED=0, BUS_BUSY=0.
  - State=IDLE; filters preset to 1.
- Reset assertion releases SDA immediately, asynchronously, including mid-transfer.
- Input-to-decision latency is 2 + FILT_LEN CLK40 cycles.
- SDA_OE changes 1 CLK40 cycle after `scl_fall`, giving hold ≥ 3+FILT_LEN cycles after the SCL pin falls.
- Minimum SCL high or low time is FILT_LEN+4 CLK40 cycles. With the defaults that is 175 ns, so 1 MHz SCL is supported.
- Glitches shorter than FILT_LEN cycles on either line are rejected.
- REG_RDATA is sampled in the same cycle as the `scl_fall` that starts a read byte. It must be stable one cycle after REG_ADDR changes.
- START and a data bit edge never coincide on filtered lines; START has priority if both are flagged in the same cycle.

## Test plan
- Write burst: START, 0xA0, 0x03, 0x11, 0x22, STOP → ACK on all bytes; REG_WE pulses with (ADDR 3, 0x11) then (ADDR 4, 0x22); final pointer 5.
- Repeated-START read: write pointer 0x0E, Sr, 0xA1, master ACKs 3 bytes then NACKs the 4th → returns regs 0xE, 0xF, 0x0, 0x1 (wrap); SDA released after NACK; SELECTED=0 after STOP.
- Address mismatch: START, 0xA2, data bytes → SDA_OE never asserted; no REG_WE; BUS_BUSY=1 until STOP.
- Glitch rejection: 2-cycle low pulse on SCL during a write byte → no bit counted, byte decoded correctly; 3-cycle pulse → counted.
- Reset mid-read with SDA_OE=1: RST_N low → SDA_OE=0 in the same cycle; after release, state IDLE, pointer 0, next transaction decoded normally.
- Three instances on the DAQ/TRG/NVIO links with the existing master test fixture (sequence 0xA1 then 12 bytes) → all ACKs received; the master reports no error status.

Source files
------------

// File: rtl/i2c_resp_regs.sv
// I2C target with a byte-wide register bus and auto-incrementing pointer.
// SCL/SDA are oversampled on CLK40, filtered, then decoded by one FSM.
module i2c_resp_regs #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         PTR_BITS   = 4,
    parameter int         FILT_LEN   = 3
) (
    input  logic                CLK40,
    input  logic                RST_N,
    input  logic                SCL_IN,
    input  logic                SDA_IN,
    output logic                SDA_OE,
    output logic [PTR_BITS-1:0] REG_ADDR,
    output logic [7:0]          REG_WDATA,
    output logic                REG_WE,
    input  logic [7:0]          REG_RDATA,
    output logic                SELECTED,
    output logic                BUS_BUSY
);

    localparam int             CW     = $clog2(FILT_LEN + 1);
    localparam logic [CW-1:0]  C_LAST = CW'(FILT_LEN - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_PTR,
        S_PTR_ACK,
        S_WDATA,
        S_WDATA_ACK,
        S_RDATA,
        S_RDATA_ACK,
        S_WAIT_STOP
    } state_t;

    logic                r_scl_s1;
    logic                r_scl_s2;
    logic                r_sda_s1;
    logic                r_sda_s2;
    logic                r_scl_f;
    logic                r_sda_f;
    logic [CW-1:0]       r_scl_cnt;
    logic [CW-1:0]       r_sda_cnt;
    logic                r_scl_d;
    logic                r_sda_d;

    state_t              r_state;
    logic [2:0]          r_bit_cnt;
    logic [6:0]          r_rx;
    logic [6:0]          r_tx;
    logic                r_rw;
    logic                r_ack_pend;
    logic                r_full;
    logic                r_inc_pend;
    logic                r_oe;
    logic                r_sel;
    logic                r_busy;
    logic                r_we;
    logic [7:0]          r_wdata;
    logic [PTR_BITS-1:0] r_ptr;

    logic                w_scl_rise;
    logic                w_scl_fall;
    logic                w_start;
    logic                w_stop;
    logic [7:0]          w_byte;

    // Two-flop synchronizers; idle bus level is high.
    always_ff @(posedge CLK40 or negedge RST_N) begin
        if (!RST_N) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
        end else begin
            r_scl_s1 <= SCL_IN;
            r_scl_s2 <= r_scl_s1;
            r_sda_s1 <= SDA_IN;
            r_sda_s2 <= r_sda_s1;
        end
    end

    // SCL filter: accept a new level after FILT_LEN equal samples.
    always_ff @(posedge CLK40 or negedge RST_N) begin
        if (!RST_N) begin
            r_scl_f   <= 1'b1;
            r_scl_cnt <= '0;
        end else if (r_scl_s2 != r_scl_f) begin
            if (r_scl_cnt == C_LAST) begin
                r_scl_f   <= r_scl_s2;
                r_scl_cnt <= '0;
            end else begin
                r_scl_cnt <= r_scl_cnt + 1'b1;
            end
        end else begin
            r_scl_cnt <= '0;
        end
    end

    // SDA filter: same rule as SCL so both lines see equal latency.
    always_ff @(posedge CLK40 or negedge RST_N) begin
        if (!RST_N) begin
            r_sda_f   <= 1'b1;
            r_sda_cnt <= '0;
        end else if (r_sda_s2 != r_sda_f) begin
            if (r_sda_cnt == C_LAST) begin
                r_sda_f   <= r_sda_s2;
                r_sda_cnt <= '0;
            end else begin
                r_sda_cnt <= r_sda_cnt + 1'b1;
            end
        end else begin
            r_sda_cnt <= '0;
        end
    end

    // Previous filtered levels for edge and bus-condition detection.
    always_ff @(posedge CLK40 or negedge RST_N) begin
        if (!RST_N) begin
            r_scl_d <= 1'b1;
            r_sda_d <= 1'b1;
        end else begin
            r_scl_d <= r_scl_f;
            r_sda_d <= r_sda_f;
        end
    end

    assign w_scl_rise = r_scl_f & ~r_scl_d;
    assign w_scl_fall = ~r_scl_f & r_scl_d;
    assign w_start    = r_scl_f & r_sda_d & ~r_sda_f;
    assign w_stop     = r_scl_f & ~r_sda_d & r_sda_f;
    assign w_byte     = {r_rx, r_sda_f};

    // Protocol FSM with registered bus and register-port outputs.
    always_ff @(posedge CLK40 or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= 3'd0;
            r_rx       <= '0;
            r_tx       <= '0;
            r_rw       <= 1'b0;
            r_ack_pend <= 1'b0;
            r_full     <= 1'b0;
            r_inc_pend <= 1'b0;
            r_oe       <= 1'b0;
            r_sel      <= 1'b0;
            r_busy     <= 1'b0;
            r_we       <= 1'b0;
            r_wdata    <= 8'h00;
            r_ptr      <= '0;
        end else begin
            r_we <= 1'b0;
            if (r_inc_pend) begin
                r_ptr      <= r_ptr + 1'b1;
                r_inc_pend <= 1'b0;
            end
            if (w_start) begin
                r_state    <= S_ADDR;
                r_bit_cnt  <= 3'd0;
                r_ack_pend <= 1'b0;
                r_full     <= 1'b0;
                r_oe       <= 1'b0;
                r_sel      <= 1'b0;
                r_busy     <= 1'b1;
            end else if (w_stop) begin
                r_state    <= S_IDLE;
                r_bit_cnt  <= 3'd0;
                r_ack_pend <= 1'b0;
                r_full     <= 1'b0;
                r_oe       <= 1'b0;
                r_sel      <= 1'b0;
                r_busy     <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_WAIT_STOP: begin
                        r_oe <= 1'b0;
                    end
                    S_ADDR: begin
                        if (w_scl_rise) begin
                            r_rx      <= w_byte[6:0];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                if (w_byte[7:1] == SLAVE_ADDR) begin
                                    r_rw       <= w_byte[0];
                                    r_ack_pend <= 1'b1;
                                end else begin
                                    r_state <= S_WAIT_STOP;
                                end
                            end
                        end else if (w_scl_fall && r_ack_pend) begin
                            r_ack_pend <= 1'b0;
                            r_oe       <= 1'b1;
                            r_sel      <= 1'b1;
                            r_state    <= S_ADDR_ACK;
                        end
                    end
                    S_ADDR_ACK: begin
                        if (w_scl_fall) begin
                            if (r_rw) begin
                                r_tx    <= REG_RDATA[6:0];
                                r_oe    <= ~REG_RDATA[7];
                                r_state <= S_RDATA;
                            end else begin
                                r_oe    <= 1'b0;
                                r_state <= S_PTR;
                            end
                        end
                    end
                    S_PTR: begin
                        if (w_scl_rise) begin
                            r_rx      <= w_byte[6:0];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_ptr      <= w_byte[PTR_BITS-1:0];
                                r_ack_pend <= 1'b1;
                            end
                        end else if (w_scl_fall && r_ack_pend) begin
                            r_ack_pend <= 1'b0;
                            r_oe       <= 1'b1;
                            r_state    <= S_PTR_ACK;
                        end
                    end
                    S_PTR_ACK: begin
                        if (w_scl_fall) begin
                            r_oe    <= 1'b0;
                            r_state <= S_WDATA;
                        end
                    end
                    S_WDATA: begin
                        if (w_scl_rise) begin
                            r_rx      <= w_byte[6:0];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_wdata    <= w_byte;
                                r_we       <= 1'b1;
                                r_inc_pend <= 1'b1;
                                r_ack_pend <= 1'b1;
                            end
                        end else if (w_scl_fall && r_ack_pend) begin
                            r_ack_pend <= 1'b0;
                            r_oe       <= 1'b1;
                            r_state    <= S_WDATA_ACK;
                        end
                    end
                    S_WDATA_ACK: begin
                        if (w_scl_fall) begin
                            r_oe    <= 1'b0;
                            r_state <= S_WDATA;
                        end
                    end
                    S_RDATA: begin
                        if (w_scl_rise) begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_full <= 1'b1;
                            end
                        end else if (w_scl_fall) begin
                            if (r_full) begin
                                r_full  <= 1'b0;
                                r_oe    <= 1'b0;
                                r_ptr   <= r_ptr + 1'b1;
                                r_state <= S_RDATA_ACK;
                            end else begin
                                r_tx <= {r_tx[5:0], 1'b0};
                                r_oe <= ~r_tx[6];
                            end
                        end
                    end
                    S_RDATA_ACK: begin
                        if (w_scl_rise) begin
                            if (r_sda_f) begin
                                r_sel   <= 1'b0;
                                r_state <= S_WAIT_STOP;
                            end
                        end else if (w_scl_fall) begin
                            r_tx    <= REG_RDATA[6:0];
                            r_oe    <= ~REG_RDATA[7];
                            r_state <= S_RDATA;
                        end
                    end
                    default: begin
                        r_oe    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign SDA_OE    = r_oe;
    assign REG_ADDR  = r_ptr;
    assign REG_WDATA = r_wdata;
    assign REG_WE    = r_we;
    assign SELECTED  = r_sel;
    assign BUS_BUSY  = r_busy;

endmodule

// File: tb/tb_i2c_resp_regs.sv
// Bench for i2c_resp_regs: bit-banged master, register file and
// a transaction-level reference model of the register space.
module tb_i2c_resp_regs;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl;
    logic       m_sda;
    logic       sda_line;
    logic       sda_oe;
    logic [3:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic [7:0] reg_rdata;
    logic       selected;
    logic       bus_busy;

    logic [7:0]  mem_dut [16];
    logic [7:0]  mem_ref [16];
    logic [11:0] wq [$];
    logic [11:0] eq [$];
    logic [7:0]  byte_q [$];
    int          ref_ptr;
    int          oe_cnt;
    int          n_vec;
    int          n_err;

    always #5 clk = ~clk;

    assign sda_line  = m_sda & ~sda_oe;
    assign reg_rdata = mem_dut[reg_addr];

    i2c_resp_regs #(
        .SLAVE_ADDR(7'h50),
        .PTR_BITS  (4),
        .FILT_LEN  (3)
    ) dut (
        .CLK40    (clk),
        .RST_N    (rst_n),
        .SCL_IN   (scl),
        .SDA_IN   (sda_line),
        .SDA_OE   (sda_oe),
        .REG_ADDR (reg_addr),
        .REG_WDATA(reg_wdata),
        .REG_WE   (reg_we),
        .REG_RDATA(reg_rdata),
        .SELECTED (selected),
        .BUS_BUSY (bus_busy)
    );

    always @(posedge clk) begin
        if (rst_n && reg_we) begin
            mem_dut[reg_addr] = reg_wdata;
            wq.push_back({reg_addr, reg_wdata});
        end
        if (sda_oe) oe_cnt++;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: sim time %0t exceeded", $time);
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clk_bit(input logic b, output logic rd);
        m_sda = b;
        tick(8);
        scl = 1'b1;
        tick(4);
        rd = sda_line;
        tick(4);
        scl = 1'b0;
        tick(4);
    endtask

    task automatic glitch_bit(input logic b, input int len);
        m_sda = b;
        tick(8);
        scl = 1'b1;
        tick(8);
        scl = 1'b0;
        tick(len);
        scl = 1'b1;
        tick(8);
        scl = 1'b0;
        tick(4);
    endtask

    task automatic start_c();
        m_sda = 1'b1;
        tick(8);
        scl = 1'b1;
        tick(8);
        m_sda = 1'b0;
        tick(8);
        scl = 1'b0;
        tick(4);
    endtask

    task automatic stop_c();
        m_sda = 1'b0;
        tick(8);
        scl = 1'b1;
        tick(8);
        m_sda = 1'b1;
        tick(12);
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], r);
        clk_bit(1'b1, r);
        ack = ~r;
    endtask

    task automatic rd_byte(input logic nack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, r);
            d[i] = r;
        end
        clk_bit(nack, r);
    endtask

    task automatic send_bytes(output int acks);
        logic a;
        acks = 0;
        foreach (byte_q[i]) begin
            wr_byte(byte_q[i], a);
            if (a) acks++;
        end
    endtask

    // Reference: a write of [ptr, d0..dn] stores d_i at (ptr+i) mod 16.
    task automatic model_write();
        logic [7:0] p;
        p = byte_q[1];
        ref_ptr = int'(p) % 16;
        for (int i = 2; i < byte_q.size(); i++) begin
            mem_ref[ref_ptr] = byte_q[i];
            eq.push_back({4'(ref_ptr), byte_q[i]});
            ref_ptr = (ref_ptr + 1) % 16;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        scl = 1'b1;
        m_sda = 1'b1;
        tick(4);
        rst_n = 1'b1;
        tick(3);
        ref_ptr = 0;
        n_vec += 6;
        if (sda_oe !== 1'b0) begin
            n_err++;
            $display("FAIL reset_oe: got %b want 0", sda_oe);
        end
        if (reg_we !== 1'b0) begin
            n_err++;
            $display("FAIL reset_we: got %b want 0", reg_we);
        end
        if (reg_wdata !== 8'h00) begin
            n_err++;
            $display("FAIL reset_wdata: got %h want 00", reg_wdata);
        end
        if (reg_addr !== 4'h0) begin
            n_err++;
            $display("FAIL reset_addr: got %h want 0", reg_addr);
        end
        if (selected !== 1'b0) begin
            n_err++;
            $display("FAIL reset_sel: got %b want 0", selected);
        end
        if (bus_busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_busy: got %b want 0", bus_busy);
        end
    endtask

    task automatic test_write_burst();
        int acks;
        wq.delete();
        eq.delete();
        byte_q = '{8'hA0, 8'h03, 8'h11, 8'h22};
        start_c();
        send_bytes(acks);
        model_write();
        n_vec += 3;
        if (acks !== 4) begin
            n_err++;
            $display("FAIL wr_acks: got %0d want 4", acks);
        end
        if (selected !== 1'b1) begin
            n_err++;
            $display("FAIL wr_sel: got %b want 1", selected);
        end
        if (bus_busy !== 1'b1) begin
            n_err++;
            $display("FAIL wr_busy: got %b want 1", bus_busy);
        end
        stop_c();
        n_vec++;
        if (wq.size() !== eq.size()) begin
            n_err++;
            $display("FAIL wr_count: got %0d want %0d", wq.size(), eq.size());
        end
        for (int i = 0; i < eq.size() && i < wq.size(); i++) begin
            n_vec++;
            if (wq[i] !== eq[i]) begin
                n_err++;
                $display("FAIL wr_strobe%0d: got %h want %h", i, wq[i], eq[i]);
            end
        end
        n_vec += 3;
        if (int'(reg_addr) !== ref_ptr || ref_ptr !== 5) begin
            n_err++;
            $display("FAIL wr_ptr: got %0d want 5", reg_addr);
        end
        if (selected !== 1'b0) begin
            n_err++;
            $display("FAIL wr_sel_stop: got %b want 0", selected);
        end
        if (bus_busy !== 1'b0) begin
            n_err++;
            $display("FAIL wr_busy_stop: got %b want 0", bus_busy);
        end
    endtask

    task automatic test_read_wrap();
        int acks;
        logic a;
        logic [7:0] d;
        logic [7:0] e;
        byte_q = '{8'hA0, 8'h0E};
        start_c();
        send_bytes(acks);
        eq.delete();
        model_write();
        start_c();
        wr_byte(8'hA1, a);
        n_vec += 3;
        if (acks !== 2 || a !== 1'b1) begin
            n_err++;
            $display("FAIL rd_acks: got %0d/%b want 2/1", acks, a);
        end
        if (selected !== 1'b1) begin
            n_err++;
            $display("FAIL rd_sel: got %b want 1", selected);
        end
        if (reg_addr !== 4'hE) begin
            n_err++;
            $display("FAIL rd_ptr0: got %h want e", reg_addr);
        end
        for (int i = 0; i < 4; i++) begin
            rd_byte(i == 3, d);
            e = mem_ref[ref_ptr];
            ref_ptr = (ref_ptr + 1) % 16;
            n_vec++;
            if (d !== e) begin
                n_err++;
                $display("FAIL rd_byte%0d: got %h want %h", i, d, e);
            end
        end
        n_vec += 2;
        if (sda_oe !== 1'b0) begin
            n_err++;
            $display("FAIL rd_nack_oe: got %b want 0", sda_oe);
        end
        if (selected !== 1'b0) begin
            n_err++;
            $display("FAIL rd_nack_sel: got %b want 0", selected);
        end
        stop_c();
        n_vec += 3;
        if (selected !== 1'b0) begin
            n_err++;
            $display("FAIL rd_sel_stop: got %b want 0", selected);
        end
        if (bus_busy !== 1'b0) begin
            n_err++;
            $display("FAIL rd_busy_stop: got %b want 0", bus_busy);
        end
        if (int'(reg_addr) !== ref_ptr) begin
            n_err++;
            $display("FAIL rd_ptr_end: got %0d want %0d", reg_addr, ref_ptr);
        end
    endtask

    task automatic test_mismatch();
        int acks;
        wq.delete();
        oe_cnt = 0;
        byte_q = '{8'hA2, 8'($urandom_range(0, 255)),
                   8'($urandom_range(0, 255))};
        start_c();
        send_bytes(acks);
        n_vec += 2;
        if (acks !== 0) begin
            n_err++;
            $display("FAIL mm_acks: got %0d want 0", acks);
        end
        if (bus_busy !== 1'b1) begin
            n_err++;
            $display("FAIL mm_busy: got %b want 1", bus_busy);
        end
        stop_c();
        n_vec += 4;
        if (bus_busy !== 1'b0) begin
            n_err++;
            $display("FAIL mm_busy_stop: got %b want 0", bus_busy);
        end
        if (oe_cnt !== 0) begin
            n_err++;
            $display("FAIL mm_oe: got %0d cycles want 0", oe_cnt);
        end
        if (wq.size() !== 0) begin
            n_err++;
            $display("FAIL mm_we: got %0d strobes want 0", wq.size());
        end
        if (int'(reg_addr) !== ref_ptr) begin
            n_err++;
            $display("FAIL mm_ptr: got %0d want %0d", reg_addr, ref_ptr);
        end
    endtask

    task automatic test_glitch();
        logic a;
        logic r;
        int acks;
        logic [7:0] p;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] b2x;
        p  = 8'($urandom_range(0, 15));
        b1 = 8'($urandom_range(0, 255));
        b2 = 8'($urandom_range(0, 255));
        wq.delete();
        eq.delete();
        acks = 0;
        start_c();
        wr_byte(8'hA0, a);
        if (a) acks++;
        wr_byte(p, a);
        if (a) acks++;
        for (int i = 7; i >= 2; i--) clk_bit(b1[i], r);
        glitch_bit(b1[1], 2);
        clk_bit(b1[0], r);
        clk_bit(1'b1, r);
        if (!r) acks++;
        for (int i = 7; i >= 2; i--) clk_bit(b2[i], r);
        glitch_bit(b2[1], 3);
        clk_bit(1'b1, r);
        if (!r) acks++;
        stop_c();
        b2x = {b2[7:1], b2[1]};
        byte_q = '{8'hA0, p, b1, b2x};
        model_write();
        n_vec += 2;
        if (acks !== 4) begin
            n_err++;
            $display("FAIL gl_acks: got %0d want 4", acks);
        end
        if (wq.size() !== 2) begin
            n_err++;
            $display("FAIL gl_count: got %0d want 2", wq.size());
        end
        for (int i = 0; i < eq.size() && i < wq.size(); i++) begin
            n_vec++;
            if (wq[i] !== eq[i]) begin
                n_err++;
                $display("FAIL gl_strobe%0d: got %h want %h", i, wq[i], eq[i]);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        int acks;
        logic a;
        logic r;
        logic [7:0] d;
        logic [7:0] x;
        byte_q = '{8'hA0, 8'h02, 8'h00};
        eq.delete();
        start_c();
        send_bytes(acks);
        stop_c();
        model_write();
        byte_q = '{8'hA0, 8'h02};
        start_c();
        send_bytes(acks);
        stop_c();
        model_write();
        start_c();
        wr_byte(8'hA1, a);
        clk_bit(1'b1, r);
        clk_bit(1'b1, r);
        tick(4);
        n_vec++;
        if (sda_oe !== 1'b1) begin
            n_err++;
            $display("FAIL mr_oe_before: got %b want 1", sda_oe);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (sda_oe !== 1'b0) begin
            n_err++;
            $display("FAIL mr_oe_async: got %b want 0", sda_oe);
        end
        scl = 1'b1;
        m_sda = 1'b1;
        tick(4);
        rst_n = 1'b1;
        ref_ptr = 0;
        tick(4);
        n_vec += 3;
        if (reg_addr !== 4'h0) begin
            n_err++;
            $display("FAIL mr_ptr: got %h want 0", reg_addr);
        end
        if (selected !== 1'b0) begin
            n_err++;
            $display("FAIL mr_sel: got %b want 0", selected);
        end
        if (bus_busy !== 1'b0) begin
            n_err++;
            $display("FAIL mr_busy: got %b want 0", bus_busy);
        end
        x = 8'($urandom_range(0, 255));
        wq.delete();
        eq.delete();
        byte_q = '{8'hA0, 8'h05, x};
        start_c();
        send_bytes(acks);
        stop_c();
        model_write();
        n_vec += 2;
        if (acks !== 3) begin
            n_err++;
            $display("FAIL mr_acks: got %0d want 3", acks);
        end
        if (wq.size() !== 1 || wq[0] !== eq[0]) begin
            n_err++;
            $display("FAIL mr_strobe: got %0d/%h want 1/%h",
                     wq.size(), (wq.size() > 0) ? wq[0] : 12'h0, eq[0]);
        end
        byte_q = '{8'hA0, 8'h05};
        start_c();
        send_bytes(acks);
        model_write();
        start_c();
        wr_byte(8'hA1, a);
        rd_byte(1'b1, d);
        stop_c();
        n_vec++;
        if (d !== mem_ref[5]) begin
            n_err++;
            $display("FAIL mr_readback: got %h want %h", d, mem_ref[5]);
        end
        ref_ptr = (ref_ptr + 1) % 16;
    endtask

    task automatic test_back_to_back();
        int acks;
        int n;
        logic a;
        logic [7:0] d;
        logic [7:0] e;
        for (int t = 0; t < 8; t++) begin
            n = $urandom_range(1, 3);
            start_c();
            if ($urandom_range(0, 1) == 1) begin
                wq.delete();
                eq.delete();
                byte_q = '{8'hA0, 8'($urandom_range(0, 255))};
                for (int k = 0; k < n; k++)
                    byte_q.push_back(8'($urandom_range(0, 255)));
                send_bytes(acks);
                model_write();
                n_vec += 3;
                if (acks !== n + 2) begin
                    n_err++;
                    $display("FAIL bb%0d_acks: got %0d want %0d", t, acks, n + 2);
                end
                if (int'(reg_addr) !== ref_ptr) begin
                    n_err++;
                    $display("FAIL bb%0d_ptr: got %0d want %0d", t, reg_addr, ref_ptr);
                end
                if (wq.size() !== eq.size()) begin
                    n_err++;
                    $display("FAIL bb%0d_count: got %0d want %0d", t, wq.size(), eq.size());
                end
                for (int i = 0; i < eq.size() && i < wq.size(); i++) begin
                    n_vec++;
                    if (wq[i] !== eq[i]) begin
                        n_err++;
                        $display("FAIL bb%0d_strobe%0d: got %h want %h", t, i, wq[i], eq[i]);
                    end
                end
            end else begin
                wr_byte(8'hA1, a);
                n_vec++;
                if (a !== 1'b1) begin
                    n_err++;
                    $display("FAIL bb%0d_rdack: got %b want 1", t, a);
                end
                for (int i = 0; i < n; i++) begin
                    rd_byte(i == n - 1, d);
                    e = mem_ref[ref_ptr];
                    ref_ptr = (ref_ptr + 1) % 16;
                    n_vec++;
                    if (d !== e) begin
                        n_err++;
                        $display("FAIL bb%0d_rd%0d: got %h want %h", t, i, d, e);
                    end
                end
            end
            if ($urandom_range(0, 1) == 1) stop_c();
        end
        stop_c();
        n_vec++;
        if (bus_busy !== 1'b0) begin
            n_err++;
            $display("FAIL bb_busy_end: got %b want 0", bus_busy);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        oe_cnt = 0;
        rst_n = 1'b0;
        scl = 1'b1;
        m_sda = 1'b1;
        for (int i = 0; i < 16; i++) begin
            mem_dut[i] = 8'($urandom_range(0, 255));
            mem_ref[i] = mem_dut[i];
        end
        test_reset();
        test_write_burst();
        test_read_wrap();
        test_mismatch();
        test_glitch();
        test_reset_mid_read();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
